// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester data-memory arbiter (IDLE/ACCESS/DONE); define DMEM_ARB_ROUND_ROBIN_EN for round-robin ties, else A wins ties
module dmem_arbiter #(
  parameter int AW = 5,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_in,
  output logic          mem_read,
  input  logic [DW-1:0] mem_out
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state;
  logic op_we, gnt_b, pick_b;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_b;
  assign pick_b = b_req & (~a_req | ~last_b);
  // remember who won the last grant so the next tie goes the other way
  always_ff @(posedge clk)
    if (rst) last_b <= 1'b1;
    else if (state == IDLE && (a_req | b_req)) last_b <= pick_b;
`else
  assign pick_b = b_req & ~a_req;
`endif
  // grant, one memory access cycle, then a single ack cycle before the next grant
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mem_read <= 1'b1;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      mem_addr <= '0;
      mem_in   <= '0;
      a_rdata  <= '0;
      b_rdata  <= '0;
      op_we    <= 1'b0;
      gnt_b    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (a_req | b_req) begin
          gnt_b    <= pick_b;
          op_we    <= pick_b ? b_we : a_we;
          mem_addr <= pick_b ? b_addr : a_addr;
          mem_in   <= pick_b ? b_wdata : a_wdata;
          mem_read <= ~(pick_b ? b_we : a_we);
          state    <= ACCESS;
        end
        ACCESS: begin
          if (gnt_b) begin
            b_rdata <= op_we ? mem_in : mem_out;
            b_ack   <= 1'b1;
          end else begin
            a_rdata <= op_we ? mem_in : mem_out;
            a_ack   <= 1'b1;
          end
          mem_read <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random and directed checks of dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
  logic clk = 1'b0, rst = 1'b1, load = 1'b1, chk_en = 1'b0;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [4:0] a_addr = 0, b_addr = 0;
  logic [15:0] a_wdata = 0, b_wdata = 0;
  logic a_ack, b_ack, mem_read;
  logic [15:0] a_rdata, b_rdata, mem_in, mem_out;
  logic [4:0] mem_addr;
  logic [15:0] mem [32];
  int ncmp = 0, nbad = 0, dut_acks = 0, exp_acks = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (.clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_read(mem_read), .mem_out(mem_out));

  // memory: preload mem[i]=i, otherwise writes whenever mem_read is low
  assign mem_out = mem[mem_addr];
  always @(posedge clk)
    if (load) for (int i = 0; i < 32; i++) mem[i] <= 16'(i);
    else if (!mem_read) mem[mem_addr] <= mem_in;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // transaction-level model: busy = cycles left in the current transaction
  logic [15:0] mm [32];
  logic e_read = 1, e_aack = 0, e_back = 0, last_b = 1, t_b = 0, t_we = 0;
  logic [4:0] e_addr = 0, t_addr = 0;
  logic [15:0] e_in = 0, e_ar = 0, e_br = 0, t_wd = 0, rd;
  int busy = 0;
  always @(posedge clk) begin
    if (load) for (int i = 0; i < 32; i++) mm[i] = 16'(i);
    else if (!e_read) mm[e_addr] = e_in;
    if (rst) begin
      e_read = 1; e_aack = 0; e_back = 0; e_addr = 0; e_in = 0; e_ar = 0; e_br = 0; busy = 0; last_b = 1;
    end else if (busy == 1) begin
      e_aack = 0; e_back = 0; busy = 0;
    end else if (busy == 2) begin
      rd = t_we ? t_wd : mm[t_addr];
      if (t_b) begin e_br = rd; e_back = 1; end else begin e_ar = rd; e_aack = 1; end
      e_read = 1; busy = 1; exp_acks++;
    end else if (a_req || b_req) begin
      if (a_req && b_req) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        t_b = !last_b;
`else
        t_b = 0;
`endif
      end else t_b = b_req;
      last_b = t_b;
      t_we = t_b ? b_we : a_we;
      t_addr = t_b ? b_addr : a_addr;
      t_wd = t_b ? b_wdata : a_wdata;
      e_addr = t_addr; e_in = t_wd; e_read = !t_we; busy = 2;
    end
  end

  // single compare process against the model on every cycle
  always @(negedge clk) if (chk_en) begin
    check("mem_read", mem_read, e_read);
    check("mem_addr", mem_addr, e_addr);
    check("mem_in", mem_in, e_in);
    check("a_ack", a_ack, e_aack);
    check("b_ack", b_ack, e_back);
    check("a_rdata", a_rdata, e_ar);
    check("b_rdata", b_rdata, e_br);
    check("both_acks", a_ack & b_ack, 0);
    if (a_ack | b_ack) dut_acks++;
  end

  task automatic do_req(input bit sb, input bit we, input logic [4:0] ad, input logic [15:0] wd,
                        output logic [15:0] r, output int lows, output int lat);
    bit got = 0;
    lows = 0; r = '0; lat = -1;
    if (sb) begin b_req = 1; b_we = we; b_addr = ad; b_wdata = wd; end
    else begin a_req = 1; a_we = we; a_addr = ad; a_wdata = wd; end
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (!mem_read) lows++;
      if (sb ? b_ack : a_ack) begin got = 1; lat = i; r = sb ? b_rdata : a_rdata; end
    end
    check("ack_seen", 32'(got), 1);
    a_req = 0; b_req = 0;
    @(negedge clk);
    check("ack_cleared", sb ? b_ack : a_ack, 0);
  endtask

  initial begin
    logic [15:0] r;
    int lows, lat, nacks, lastpos;
    bit ah = 0, bh = 0;
    logic [7:0] seq [$];
    repeat (2) @(negedge clk);
    chk_en = 1;
    rst = 0; load = 0;
    check("rst_mem_read", mem_read, 1);
    check("rst_a_ack", a_ack, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_b_rdata", b_rdata, 0);
    // read of preloaded address 7
    do_req(0, 0, 5'd7, 16'h0, r, lows, lat);
    check("rd7_data", r, 16'h0007);
    check("rd7_lat", lat, 1);
    check("rd7_no_write", lows, 0);
    // B writes BEEF to addr 3, A reads it back
    do_req(1, 1, 5'd3, 16'hBEEF, r, lows, lat);
    check("wr3_rdata", r, 16'hBEEF);
    check("wr3_low_cycles", lows, 1);
    check("wr3_a_untouched", a_rdata, 16'h0007);
    do_req(0, 0, 5'd3, 16'h0, r, lows, lat);
    check("rd3_data", r, 16'hBEEF);
    // both requesters held continuously right after a reset
    rst = 1; @(negedge clk); rst = 0;
    a_req = 1; a_we = 0; a_addr = 5'd1; b_req = 1; b_we = 0; b_addr = 5'd2;
    nacks = 0; lastpos = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (a_ack | b_ack) begin
        seq.push_back(a_ack ? "A" : "B");
        if (lastpos >= 0) check("tie_spacing", i - lastpos, 3);
        lastpos = i; nacks++;
      end
    end
    a_req = 0; b_req = 0;
    check("tie_ack_count", nacks, 4);
    for (int i = 0; i < seq.size(); i++)
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      check("tie_order", seq[i], (i % 2) ? "B" : "A");
`else
      check("tie_order", seq[i], "A");
`endif
    repeat (3) @(negedge clk);
    // reset during ACCESS of an A write to addr 5
    a_req = 1; a_we = 1; a_addr = 5'd5; a_wdata = 16'h1234;
    @(negedge clk);
    check("wr5_access_low", mem_read, 0);
    a_req = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    check("wr5_rst_mem_read", mem_read, 1);
    check("wr5_rst_no_ack", a_ack, 0);
    check("wr5_rst_addr", mem_addr, 0);
    check("wr5_applied", mem[5], 16'h1234);
    repeat (2) @(negedge clk);
    check("wr5_never_acked", a_ack, 0);
    // random traffic
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 249) == 0);
      if (ah && a_ack) ah = 0;
      else if (!ah && $urandom_range(0, 2) == 0) begin
        ah = 1; a_we = 1'($urandom); a_addr = 5'($urandom); a_wdata = 16'($urandom);
      end
      if (bh && b_ack) bh = 0;
      else if (!bh && $urandom_range(0, 2) == 0) begin
        bh = 1; b_we = 1'($urandom); b_addr = 5'($urandom); b_wdata = 16'($urandom);
      end
      a_req = ah; b_req = bh;
    end
    rst = 0; a_req = 0; b_req = 0;
    repeat (4) @(negedge clk);
    check("ack_count", dut_acks, exp_acks);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
